// File: rtl/rv_encode_pkg.sv
// Shared RV32I encoding definitions: opcode constants, format codes,
// the halt word and the field bundle handed to the encoder.
package rv_encode_pkg;

    localparam logic [6:0] R_TYPE  = 7'h33;
    localparam logic [6:0] I_LOGIC = 7'h13;
    localparam logic [6:0] I_LW    = 7'h03;
    localparam logic [6:0] I_JALR  = 7'h67;
    localparam logic [6:0] U_TYPE  = 7'h37;
    localparam logic [6:0] B_TYPE  = 7'h63;
    localparam logic [6:0] S_TYPE  = 7'h23;
    localparam logic [6:0] J_TYPE  = 7'h6F;

    // jal x0, 0 : a tight self-loop that parks the core at the end of a program
    localparam logic [31:0] HALT_WORD = 32'h0000_006F;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } instr_fields_t;

endpackage

// File: rtl/rv_field_encoder.sv
// Combinational RV32I field-to-word encoder; flags format/opcode mismatches
// and misaligned branch/jump offsets as illegal.
module rv_field_encoder
    import rv_encode_pkg::*;
(
    input  instr_fields_t i_fields,
    output logic [31:0]   o_word,
    output logic          o_illegal
);

    logic [31:0] w_imm;
    assign w_imm = i_fields.imm;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (i_fields.fmt)
            FMT_R: begin
                o_word    = {i_fields.f7, i_fields.rs2, i_fields.rs1, i_fields.f3, i_fields.rd, i_fields.op};
                o_illegal = (i_fields.op != R_TYPE);
            end
            FMT_I: begin
                o_word    = {w_imm[11:0], i_fields.rs1, i_fields.f3, i_fields.rd, i_fields.op};
                o_illegal = !((i_fields.op == I_LOGIC) || (i_fields.op == I_LW) || (i_fields.op == I_JALR));
            end
            FMT_S: begin
                o_word    = {w_imm[11:5], i_fields.rs2, i_fields.rs1, i_fields.f3, w_imm[4:0], i_fields.op};
                o_illegal = (i_fields.op != S_TYPE);
            end
            FMT_B: begin
                o_word    = {w_imm[12], w_imm[10:5], i_fields.rs2, i_fields.rs1, i_fields.f3,
                             w_imm[4:1], w_imm[11], i_fields.op};
                o_illegal = (i_fields.op != B_TYPE) || w_imm[0];
            end
            FMT_U: begin
                o_word    = {w_imm[31:12], i_fields.rd, i_fields.op};
                o_illegal = (i_fields.op != U_TYPE);
            end
            FMT_J: begin
                o_word    = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_fields.rd, i_fields.op};
                o_illegal = (i_fields.op != J_TYPE) || w_imm[0];
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts RV32I field descriptions over valid/ready, encodes them and writes
// sequential words from BASE_ADDRESS. Define HALT_APPEND_EN to add Done_i halt insertion.
module instr_encoder_loader
    import rv_encode_pkg::*;
#(
    parameter int          DEPTH        = 64,
    parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Clear_i,
    input  logic                   Valid_i,
    output logic                   Ready_o,
    input  logic [2:0]             Format_i,
    input  logic [6:0]             OP_i,
    input  logic [4:0]             Rd_i,
    input  logic [4:0]             Rs1_i,
    input  logic [4:0]             Rs2_i,
    input  logic [2:0]             Funct3_i,
    input  logic [6:0]             Funct7_i,
    input  logic [31:0]            Imm_i,
`ifdef HALT_APPEND_EN
    input  logic                   Done_i,
`endif
    output logic                   Mem_Write_o,
    output logic [31:0]            Mem_Address_o,
    output logic [31:0]            Mem_Data_o,
    output logic [$clog2(DEPTH):0] Count_o,
    output logic                   Full_o,
    output logic                   Error_o
);

    localparam int              CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_CNT = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]    r_state;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic [CW-1:0] r_count;
    logic          r_error;
    logic          r_halt;

    instr_fields_t w_fields;
    logic [31:0]   w_word;
    logic          w_illegal;
    logic          w_done;
    logic          w_accept;
    logic [CW-1:0] w_count_inc;

    assign w_fields = '{fmt: Format_i, op: OP_i, rd: Rd_i, rs1: Rs1_i, rs2: Rs2_i,
                        f3: Funct3_i, f7: Funct7_i, imm: Imm_i};

    rv_field_encoder u_encoder (
        .i_fields  (w_fields),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign Full_o      = (r_count == DEPTH_CNT);
    assign Ready_o     = (r_state == S_IDLE) && !Full_o;
    assign Mem_Write_o = (r_state == S_WRITE);
    assign w_count_inc = r_count + CW'(1);

`ifdef HALT_APPEND_EN
    assign w_done = Done_i && (r_state == S_IDLE) && !Full_o && !Clear_i;
`else
    assign w_done = 1'b0;
`endif
    // Halt insertion wins over a simultaneous field request
    assign w_accept = Valid_i && Ready_o && !Clear_i && !w_done;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_addr  <= BASE_ADDRESS;
            r_data  <= '0;
            r_count <= '0;
            r_error <= 1'b0;
            r_halt  <= 1'b0;
        end else if (Clear_i) begin
            r_state <= S_IDLE;
            r_addr  <= BASE_ADDRESS;
            r_count <= '0;
            r_error <= 1'b0;
            r_halt  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_done) begin
                        r_data  <= HALT_WORD;
                        r_halt  <= 1'b1;
                        r_state <= S_WRITE;
                    end else if (w_accept) begin
                        if (w_illegal) begin
                            r_error <= 1'b1;
                        end else begin
                            r_data  <= w_word;
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_addr  <= r_addr + 32'd4;
                    r_count <= w_count_inc;
                    r_halt  <= 1'b0;
                    r_state <= (r_halt || (w_count_inc == DEPTH_CNT)) ? S_FULL : S_IDLE;
                end
                S_FULL:  r_state <= S_FULL;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Mem_Address_o = r_addr;
    assign Mem_Data_o    = r_data;
    assign Count_o       = r_count;
    assign Error_o       = r_error;

endmodule
